// File: rtl/seg_scan_decoder_pkg.sv
// seg_pkg: shared constants and types for the seven-segment scan decoder.
//   NUM_DIGITS      number of scanned positions (HH . MM . SS with two separators)
//   SEP_POS_A/B     positions that carry the separator dot instead of a digit
//   SEG_0..SEG_9    legal a-g patterns for the decimal digits, bit order {g,f,e,d,c,b,a}
//   seg_state_e     scan-tracking FSM states
//   is_sep()        true for a separator position
package seg_pkg;

   localparam int NUM_DIGITS = 8;
   localparam int SEP_POS_A  = 2;
   localparam int SEP_POS_B  = 5;

   localparam logic [6:0] SEG_0 = 7'h3F;
   localparam logic [6:0] SEG_1 = 7'h06;
   localparam logic [6:0] SEG_2 = 7'h5B;
   localparam logic [6:0] SEG_3 = 7'h4F;
   localparam logic [6:0] SEG_4 = 7'h66;
   localparam logic [6:0] SEG_5 = 7'h6D;
   localparam logic [6:0] SEG_6 = 7'h7D;
   localparam logic [6:0] SEG_7 = 7'h07;
   localparam logic [6:0] SEG_8 = 7'h7F;
   localparam logic [6:0] SEG_9 = 7'h6F;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_HELD   = 2'd2
   } seg_state_e;

   function automatic logic is_sep(input int pos);
      return (pos == SEP_POS_A) || (pos == SEP_POS_B);
   endfunction

endpackage

// File: rtl/seg_scan_decoder_if.sv
// seg_scan_decoder_if: display-scan input bus and decoded-time output bus.
//   i_cs     digit select, active-low one-hot (position 0 = hours tens)
//   i_seg    segments, active-high {dp,g,f,e,d,c,b,a}
//   o_hh/o_mm/o_ss  last good frame, packed BCD {tens,units}
//   o_valid / o_err one-cycle pulse per good / bad frame
//   o_stale  level, no digit accepted for the timeout period
//   state    debug view of the scan-tracking FSM
// Handshake: the scan inputs have no flow control; every cycle is a sample.
// o_valid and o_err are single-cycle strobes, never asserted together, and
// o_hh/o_mm/o_ss change only in the o_valid cycle.
interface seg_scan_decoder_if;
   import seg_pkg::*;

   logic [7:0] i_cs;
   logic [7:0] i_seg;
   logic [7:0] o_hh;
   logic [7:0] o_mm;
   logic [7:0] o_ss;
   logic       o_valid;
   logic       o_err;
   logic       o_stale;
   seg_state_e state;

   modport master (
      output i_cs, i_seg,
      input  o_hh, o_mm, o_ss, o_valid, o_err, o_stale, state
   );

   modport slave (
      input  i_cs, i_seg,
      output o_hh, o_mm, o_ss, o_valid, o_err, o_stale, state
   );

endinterface

// File: rtl/seg_scan_decoder_seg7_to_bcd.sv
// seg7_to_bcd: combinational decode of a seven-segment a-g pattern.
//   seg_ag  segment bits {g,f,e,d,c,b,a}; the dot is stripped by the caller
//   legal   pattern is exactly one of the ten digit shapes
//   digit   decoded value 0-9 (0 when not legal)
module seg7_to_bcd
   import seg_pkg::*;
(
   input  logic [6:0] seg_ag,
   output logic       legal,
   output logic [3:0] digit
);

   always_comb begin
      legal = 1'b1;
      digit = 4'd0;
      case (seg_ag)
         SEG_0:   digit = 4'd0;
         SEG_1:   digit = 4'd1;
         SEG_2:   digit = 4'd2;
         SEG_3:   digit = 4'd3;
         SEG_4:   digit = 4'd4;
         SEG_5:   digit = 4'd5;
         SEG_6:   digit = 4'd6;
         SEG_7:   digit = 4'd7;
         SEG_8:   digit = 4'd8;
         SEG_9:   digit = 4'd9;
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: rebuilds HH.MM.SS from a multiplexed 8-digit LED scan.
//   i_clk  single clock, rising edge
//   i_rst  synchronous active-high reset
//   bus    seg_scan_decoder_if.slave (scan inputs, decoded outputs, FSM state)
// A digit is accepted once {i_cs,i_seg} has been identical and valid for
// STABLE_CYCLES consecutive samples. When all eight positions have been
// captured the frame is checked the next cycle and one of o_valid/o_err pulses.
module seg_scan_decoder
   import seg_pkg::*;
#(
   parameter int STABLE_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                i_clk,
   input  logic                i_rst,
   seg_scan_decoder_if.slave   bus
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] STABLE_MAX  = CW'(STABLE_CYCLES);
   localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

   logic [7:0] cs;
   logic [7:0] seg;
   assign cs  = bus.i_cs;
   assign seg = bus.i_seg;

   // Scan sample qualification
   logic       cs_ok;
   logic [2:0] pos;
   logic       same;
   logic [7:0] prev_cs_q;
   logic [7:0] prev_seg_q;

   assign cs_ok = ($countones(~cs) == 1);
   assign same  = (cs == prev_cs_q) && (seg == prev_seg_q);

   always_comb begin
      pos = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (!cs[k]) pos = 3'(k);
      end
   end

   // FSM: state register
   seg_state_e    state_q, state_n;
   logic [CW-1:0] cnt_q, cnt_n;
   logic          accept;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         prev_cs_q  <= '0;
         prev_seg_q <= '0;
      end else begin
         state_q    <= state_n;
         cnt_q      <= cnt_n;
         prev_cs_q  <= cs;
         prev_seg_q <= seg;
      end
   end

   // FSM: next state. The count never passes STABLE_MAX because reaching it
   // moves the FSM to S_HELD, where it stays until the sample changes.
   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      if (!cs_ok) begin
         state_n = S_IDLE;
         cnt_n   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_n = S_SETTLE;
               cnt_n   = CW'(1);
            end
            S_SETTLE: begin
               cnt_n = same ? cnt_q + CW'(1) : CW'(1);
            end
            S_HELD: begin
               if (!same) begin
                  state_n = S_SETTLE;
                  cnt_n   = CW'(1);
               end
            end
            default: begin
               state_n = S_IDLE;
               cnt_n   = '0;
            end
         endcase
         if (state_n == S_SETTLE && cnt_n == STABLE_MAX) state_n = S_HELD;
      end
   end

   // FSM: outputs. A held, unchanged sample never re-accepts.
   always_comb begin
      accept = cs_ok && (cnt_n == STABLE_MAX) && !(state_q == S_HELD && same);
   end

   assign bus.state = state_q;

   // Captured bytes and per-position decode
   logic [7:0] bytes_q [NUM_DIGITS];
   logic       legal   [NUM_DIGITS];
   logic [3:0] digit   [NUM_DIGITS];

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
      seg7_to_bcd u_dec (
         .seg_ag (bytes_q[g][6:0]),
         .legal  (legal[g]),
         .digit  (digit[g])
      );
   end

   // Frame check: digits must decode, separators need the dot, and the
   // time must be in range.
   logic       frame_good;
   logic [6:0] hh_bin, mm_bin, ss_bin;

   always_comb begin
      hh_bin     = 7'(digit[0]) * 7'd10 + 7'(digit[1]);
      mm_bin     = 7'(digit[3]) * 7'd10 + 7'(digit[4]);
      ss_bin     = 7'(digit[6]) * 7'd10 + 7'(digit[7]);
      frame_good = (hh_bin <= 7'd23) && (mm_bin <= 7'd59) && (ss_bin <= 7'd59);
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (is_sep(i)) frame_good = frame_good & bytes_q[i][7];
         else           frame_good = frame_good & legal[i];
      end
   end

   // Capture mask: cleared in the evaluation cycle, but an acceptance in that
   // same cycle lands in the cleared mask so it counts toward the next frame.
   logic [7:0] mask_q, mask_n;
   logic       frame_done;

   assign frame_done = (mask_q == 8'hFF);

   always_comb begin
      mask_n = frame_done ? 8'h00 : mask_q;
      if (accept) mask_n[pos] = 1'b1;
   end

   logic [TW-1:0] tcnt_q;
   logic [7:0]    hh_q, mm_q, ss_q;
   logic          valid_q, err_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         mask_q  <= '0;
         tcnt_q  <= '0;
         hh_q    <= '0;
         mm_q    <= '0;
         ss_q    <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         for (int i = 0; i < NUM_DIGITS; i++) bytes_q[i] <= '0;
      end else begin
         mask_q  <= mask_n;
         valid_q <= frame_done && frame_good;
         err_q   <= frame_done && !frame_good;
         if (accept) bytes_q[pos] <= seg;
         if (frame_done && frame_good) begin
            hh_q <= {digit[0], digit[1]};
            mm_q <= {digit[3], digit[4]};
            ss_q <= {digit[6], digit[7]};
         end
         // Acceptance takes priority over saturation.
         if (accept)                     tcnt_q <= '0;
         else if (tcnt_q != TIMEOUT_MAX) tcnt_q <= tcnt_q + TW'(1);
      end
   end

   assign bus.o_hh    = hh_q;
   assign bus.o_mm    = mm_q;
   assign bus.o_ss    = ss_q;
   assign bus.o_valid = valid_q;
   assign bus.o_err   = err_q;
   assign bus.o_stale = (tcnt_q == TIMEOUT_MAX);

endmodule

// File: tb/tb_seg_scan_decoder.sv
module tb_seg_scan_decoder;
   import seg_pkg::*;

   localparam int STABLE = 16;
   localparam int TMO    = 50;

   // Clock / reset
   logic i_clk = 1'b0;
   logic i_rst = 1'b1;
   always #5 i_clk = ~i_clk;

   seg_scan_decoder_if bus ();

   seg_scan_decoder #(
      .STABLE_CYCLES  (STABLE),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   // Digit shapes, a-g only
   logic [6:0] pat [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
   logic [7:0] frame [8];
   logic [7:0] blank_cs [3] = '{8'h00, 8'hFF, 8'hFC};

   // Reference model state
   int         run;
   bit         taken;
   logic [7:0] last_cs, last_seg;
   logic [7:0] m_bytes [8];
   logic [7:0] m_mask;
   bit         m_full;
   int         m_idle;
   logic [7:0] e_hh, e_mm, e_ss;
   bit         e_valid, e_err;
   int         n_valid_exp = 0, n_err_exp = 0, n_valid_dut = 0, n_err_dut = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int decode(input logic [7:0] s);
      for (int d = 0; d < 10; d++) if (s[6:0] == pat[d]) return d;
      return -1;
   endfunction

   task automatic evaluate();
      int  d [8];
      bit  ok;
      ok = 1'b1;
      for (int p = 0; p < 8; p++) begin
         d[p] = 0;
         if (p == 2 || p == 5) begin
            if (!m_bytes[p][7]) ok = 1'b0;
         end else begin
            d[p] = decode(m_bytes[p]);
            if (d[p] < 0) ok = 1'b0;
         end
      end
      if (ok && (d[0] * 10 + d[1] > 23 || d[3] * 10 + d[4] > 59 || d[6] * 10 + d[7] > 59))
         ok = 1'b0;
      if (ok) begin
         e_valid = 1'b1;
         e_hh = {4'(d[0]), 4'(d[1])};
         e_mm = {4'(d[3]), 4'(d[4])};
         e_ss = {4'(d[6]), 4'(d[7])};
         n_valid_exp++;
      end else begin
         e_err = 1'b1;
         n_err_exp++;
      end
   endtask

   // One clock edge of the reference behaviour
   task automatic model_edge(input logic rst, input logic [7:0] cs, input logic [7:0] seg);
      int zeros;
      int p;
      e_valid = 1'b0;
      e_err   = 1'b0;
      if (rst) begin
         run = 0; taken = 1'b0; m_mask = '0; m_full = 1'b0; m_idle = 0;
         e_hh = '0; e_mm = '0; e_ss = '0;
         for (int i = 0; i < 8; i++) m_bytes[i] = '0;
      end else begin
         if (m_full) begin
            evaluate();
            m_full = 1'b0;
            m_mask = '0;
         end
         zeros = 0;
         p = 0;
         for (int k = 0; k < 8; k++) if (!cs[k]) begin zeros++; p = k; end
         if (zeros != 1) begin
            run = 0; taken = 1'b0;
         end else if (run > 0 && cs == last_cs && seg == last_seg) begin
            if (run < STABLE) run++;
         end else begin
            run = 1; taken = 1'b0;
         end
         last_cs  = cs;
         last_seg = seg;
         if (zeros == 1 && run >= STABLE && !taken) begin
            taken = 1'b1;
            m_bytes[p] = seg;
            m_mask[p]  = 1'b1;
            m_idle     = 0;
         end else if (m_idle < TMO) begin
            m_idle++;
         end
         if (m_mask == 8'hFF) m_full = 1'b1;
      end
   endtask

   // Driver: apply one sample, advance one edge, compare all outputs
   task automatic step(input logic [7:0] cs, input logic [7:0] seg);
      bus.i_cs  = cs;
      bus.i_seg = seg;
      @(posedge i_clk);
      model_edge(i_rst, cs, seg);
      #1;
      if (bus.o_valid) n_valid_dut++;
      if (bus.o_err)   n_err_dut++;
      check("o_valid", 32'(bus.o_valid), 32'(e_valid));
      check("o_err",   32'(bus.o_err),   32'(e_err));
      check("o_hh",    32'(bus.o_hh),    32'(e_hh));
      check("o_mm",    32'(bus.o_mm),    32'(e_mm));
      check("o_ss",    32'(bus.o_ss),    32'(e_ss));
      check("o_stale", 32'(bus.o_stale), 32'(m_idle == TMO));
   endtask

   task automatic hold(input int k, input logic [7:0] seg, input int n);
      logic [7:0] cs;
      cs = ~(8'b1 << k);
      repeat (n) step(cs, seg);
   endtask

   task automatic load_time(input int h, input int m, input int s);
      frame[0] = {1'b0, pat[h / 10]};
      frame[1] = {1'b0, pat[h % 10]};
      frame[2] = 8'h80;
      frame[3] = {1'b0, pat[m / 10]};
      frame[4] = {1'b0, pat[m % 10]};
      frame[5] = 8'h80;
      frame[6] = {1'b0, pat[s / 10]};
      frame[7] = {1'b0, pat[s % 10]};
   endtask

   task automatic scan(input int n);
      for (int k = 0; k < 8; k++) hold(k, frame[k], n);
   endtask

   task automatic do_reset(input int n);
      i_rst = 1'b1;
      repeat (n) step(8'($urandom), 8'($urandom));
      i_rst = 1'b0;
   endtask

   int v0, e0;

   initial begin
      // Reset state
      do_reset(3);
      check("rst_state", 32'(bus.state), 32'(S_IDLE));

      // Idle scan: stale rises exactly 50 cycles after the last acceptance
      for (int i = 0; i < 60; i++) begin
         step(8'hFF, 8'($urandom));
         if (i == 48) check("stale_early", 32'(bus.o_stale), 32'd0);
         if (i == 49) check("stale_at_50", 32'(bus.o_stale), 32'd1);
      end

      // Good frame 12:34:56
      v0 = n_valid_dut; e0 = n_err_dut;
      load_time(12, 34, 56);
      hold(0, frame[0], 16);
      check("stale_clear", 32'(bus.o_stale), 32'd0);
      hold(0, frame[0], 4);
      for (int k = 1; k < 8; k++) hold(k, frame[k], 20);
      repeat (3) step(8'hFF, 8'h00);
      check("f1_valid_cnt", 32'(n_valid_dut - v0), 32'd1);
      check("f1_err_cnt",   32'(n_err_dut - e0),   32'd0);
      check("f1_hh", 32'(bus.o_hh), 32'h12);
      check("f1_mm", 32'(bus.o_mm), 32'h34);
      check("f1_ss", 32'(bus.o_ss), 32'h56);

      // Hour 24 is out of range: error, previous time held
      v0 = n_valid_dut; e0 = n_err_dut;
      load_time(24, 34, 56);
      scan(20);
      repeat (3) step(8'hFF, 8'h00);
      check("f2_err_cnt",   32'(n_err_dut - e0),   32'd1);
      check("f2_valid_cnt", 32'(n_valid_dut - v0), 32'd0);
      check("f2_hh_hold",   32'(bus.o_hh), 32'h12);

      // Position 4 flickers 4/5 every 10 cycles before settling on 4
      v0 = n_valid_dut;
      load_time(12, 34, 56);
      for (int k = 0; k < 4; k++) hold(k, frame[k], 20);
      for (int t = 0; t < 10; t++) hold(4, (t % 2 == 1) ? 8'h6D : 8'h66, 10);
      hold(4, 8'h66, 20);
      for (int k = 5; k < 8; k++) hold(k, frame[k], 20);
      repeat (3) step(8'hFF, 8'h00);
      check("f3_valid_cnt", 32'(n_valid_dut - v0), 32'd1);
      check("f3_mm", 32'(bus.o_mm), 32'h34);

      // Separator without dot
      e0 = n_err_dut;
      load_time(7, 45, 9);
      frame[5] = 8'h00;
      scan(20);
      repeat (3) step(8'hFF, 8'h00);
      check("f4_err_cnt", 32'(n_err_dut - e0), 32'd1);

      // Blanking between and inside digits: no error, one good frame
      v0 = n_valid_dut; e0 = n_err_dut;
      load_time(7, 45, 9);
      for (int k = 0; k < 8; k++) begin
         hold(k, frame[k], 10);
         repeat (3) step(8'h00, frame[k]);
         hold(k, frame[k], 18);
         repeat (4) step(8'h00, 8'($urandom));
      end
      repeat (3) step(8'hFF, 8'h00);
      check("f5_err_cnt",   32'(n_err_dut - e0),   32'd0);
      check("f5_valid_cnt", 32'(n_valid_dut - v0), 32'd1);
      check("f5_hh", 32'(bus.o_hh), 32'h07);
      check("f5_ss", 32'(bus.o_ss), 32'h09);

      // Reset mid-frame discards the partial capture
      v0 = n_valid_dut; e0 = n_err_dut;
      load_time(23, 59, 59);
      for (int k = 0; k < 5; k++) hold(k, frame[k], 20);
      do_reset(2);
      check("f6_rst_pulse", 32'(n_valid_dut - v0 + n_err_dut - e0), 32'd0);
      scan(20);
      repeat (3) step(8'hFF, 8'h00);
      check("f6_valid_cnt", 32'(n_valid_dut - v0), 32'd1);
      check("f6_hh", 32'(bus.o_hh), 32'h23);

      // Randomized frames with glitches, blanking, overwrites and corruption
      for (int f = 0; f < 12; f++) begin
         load_time($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
         case ($urandom_range(0, 5))
            0: frame[0] = {1'b0, pat[$urandom_range(3, 9)]};
            1: frame[3] = {1'b0, pat[$urandom_range(6, 9)]};
            2: frame[$urandom_range(6, 7)] = 8'($urandom);
            3: frame[2] = {1'b0, 7'($urandom)};
            default: ;
         endcase
         if ($urandom_range(0, 3) == 0) hold(0, {1'b0, pat[$urandom_range(0, 9)]}, 18);
         for (int k = 0; k < 8; k++) begin
            if ($urandom_range(0, 4) == 0) hold(k, 8'($urandom), $urandom_range(1, 15));
            if ($urandom_range(0, 4) == 0)
               repeat ($urandom_range(1, 4)) step(blank_cs[$urandom_range(0, 2)], 8'($urandom));
            hold(k, frame[k], $urandom_range(16, 24));
         end
         if ($urandom_range(0, 5) == 0) repeat ($urandom_range(40, 60)) step(8'hFF, 8'h00);
      end
      repeat (3) step(8'hFF, 8'h00);

      check("total_valid", 32'(n_valid_dut), 32'(n_valid_exp));
      check("total_err",   32'(n_err_dut),   32'(n_err_exp));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
